// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU control path: opcodes, datapath select
// codes, sequencer state encodings and condition-code bit positions.
package cpu_pkg;

    // Opcodes
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BCS     = 8'h26;
    localparam logic [7:0] OP_ADD     = 8'h42;
    localparam logic [7:0] OP_SUB     = 8'h43;
    localparam logic [7:0] OP_AND     = 8'h44;
    localparam logic [7:0] OP_OR      = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;

    // ALU operation select
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_INCA = 3'b100;
    localparam logic [2:0] ALU_DECA = 3'b101;

    // FROM_MEMORY_BUS source select
    localparam logic [1:0] FROM_ALU   = 2'b00;
    localparam logic [1:0] FROM_TOBUS = 2'b01;
    localparam logic [1:0] FROM_MEM   = 2'b10;

    // TO_MEMORY_BUS source select
    localparam logic [1:0] TO_PC = 2'b00;
    localparam logic [1:0] TO_A  = 2'b01;
    localparam logic [1:0] TO_B  = 2'b10;

    // CCR bit positions
    localparam int unsigned CCR_N = 3;
    localparam int unsigned CCR_Z = 2;
    localparam int unsigned CCR_V = 1;
    localparam int unsigned CCR_C = 0;

    // Sequencer states. Operand-fetch states are shared by memory ops and
    // branches; the next state after them is steered by IR.
    localparam int unsigned ST_WIDTH = 5;
    localparam logic [ST_WIDTH-1:0] S_F0       = 5'd0;
    localparam logic [ST_WIDTH-1:0] S_F1       = 5'd1;
    localparam logic [ST_WIDTH-1:0] S_F2       = 5'd2;
    localparam logic [ST_WIDTH-1:0] S_D3       = 5'd3;
    localparam logic [ST_WIDTH-1:0] S_OPA      = 5'd4;   // MAR <= PC
    localparam logic [ST_WIDTH-1:0] S_OPB      = 5'd5;   // PC_INC (also branch not-taken)
    localparam logic [ST_WIDTH-1:0] S_LDA      = 5'd6;
    localparam logic [ST_WIDTH-1:0] S_LDB      = 5'd7;
    localparam logic [ST_WIDTH-1:0] S_DIR_MAR  = 5'd8;   // MAR <= operand address
    localparam logic [ST_WIDTH-1:0] S_DIR_WAIT = 5'd9;
    localparam logic [ST_WIDTH-1:0] S_STA      = 5'd10;
    localparam logic [ST_WIDTH-1:0] S_STB      = 5'd11;
    localparam logic [ST_WIDTH-1:0] S_ADD      = 5'd12;
    localparam logic [ST_WIDTH-1:0] S_SUB      = 5'd13;
    localparam logic [ST_WIDTH-1:0] S_AND      = 5'd14;
    localparam logic [ST_WIDTH-1:0] S_OR       = 5'd15;
    localparam logic [ST_WIDTH-1:0] S_INCA     = 5'd16;
    localparam logic [ST_WIDTH-1:0] S_DECA     = 5'd17;
    localparam logic [ST_WIDTH-1:0] S_BR_WAIT  = 5'd18;
    localparam logic [ST_WIDTH-1:0] S_BR_LOAD  = 5'd19;

    // True for BRA and all conditional branches (0x20..0x26)
    function automatic logic is_branch(input logic [7:0] ir);
        return (ir >= OP_BRA) && (ir <= OP_BCS);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control interface between the sequencer and the CPU data path.
interface cpu_sequencer_if;
    logic [7:0] IR;
    logic [3:0] CCR;
    logic       IR_LOAD;
    logic       MAR_LOAD;
    logic       PC_LOAD;
    logic       PC_INC;
    logic       A_LOAD;
    logic       B_LOAD;
    logic [2:0] ALU_SEL;
    logic       CCR_LOAD;
    logic [1:0] FROM_MEMORY_BUS_SEL;
    logic [1:0] TO_MEMORY_BUS_SEL;
    logic       write;

    modport master (
        input  IR, CCR,
        output IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, ALU_SEL, CCR_LOAD,
               FROM_MEMORY_BUS_SEL, TO_MEMORY_BUS_SEL, write
    );

    modport slave (
        output IR, CCR,
        input  IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, ALU_SEL, CCR_LOAD,
               FROM_MEMORY_BUS_SEL, TO_MEMORY_BUS_SEL, write
    );
endinterface

// File: rtl/cpu_branch_eval.sv
// Branch condition evaluator: decides whether the opcode in IR is a taken branch.
module cpu_branch_eval
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir,
    input  logic [3:0] i_ccr,
    output logic       o_taken
);

    // Decode branch opcode against the condition codes; non-branches never taken
    always_comb begin
        o_taken = 1'b0;
        case (i_ir)
            OP_BRA:  o_taken = 1'b1;
            OP_BMI:  o_taken = i_ccr[CCR_N];
            OP_BPL:  o_taken = ~i_ccr[CCR_N];
            OP_BEQ:  o_taken = i_ccr[CCR_Z];
            OP_BNE:  o_taken = ~i_ccr[CCR_Z];
            OP_BVS:  o_taken = i_ccr[CCR_V];
            OP_BCS:  o_taken = i_ccr[CCR_C];
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Moore fetch/decode/execute sequencer for the 8-bit CPU. Outputs depend on
// the state register only; IR and CCR steer the next state.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned STATE_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    cpu_sequencer_if.master  ctrl
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               w_taken;

    logic       w_ir_load;
    logic       w_mar_load;
    logic       w_pc_load;
    logic       w_pc_inc;
    logic       w_a_load;
    logic       w_b_load;
    logic [2:0] w_alu_sel;
    logic       w_ccr_load;
    logic [1:0] w_from_sel;
    logic [1:0] w_to_sel;
    logic       w_write;

    cpu_branch_eval u_branch_eval (
        .i_ir    (ctrl.IR),
        .i_ccr   (ctrl.CCR),
        .o_taken (w_taken)
    );

    // State register; asynchronous reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_F0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: fetch, decode on IR/CCR, then walk the execute states
    always_comb begin
        w_state_next = S_F0;
        case (r_state)
            S_F0: w_state_next = S_F1;
            S_F1: w_state_next = S_F2;
            S_F2: w_state_next = S_D3;
            S_D3: begin
                case (ctrl.IR)
                    OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
                    OP_STA_DIR, OP_STB_DIR: w_state_next = S_OPA;
                    OP_ADD:  w_state_next = S_ADD;
                    OP_SUB:  w_state_next = S_SUB;
                    OP_AND:  w_state_next = S_AND;
                    OP_OR:   w_state_next = S_OR;
                    OP_INCA: w_state_next = S_INCA;
                    OP_DECA: w_state_next = S_DECA;
                    default: begin
                        // Not-taken branch goes straight to the PC_INC state
                        if (is_branch(ctrl.IR)) begin
                            w_state_next = w_taken ? S_OPA : S_OPB;
                        end else begin
                            w_state_next = S_F0;
                        end
                    end
                endcase
            end
            S_OPA: w_state_next = is_branch(ctrl.IR) ? S_BR_WAIT : S_OPB;
            S_OPB: begin
                case (ctrl.IR)
                    OP_LDA_IMM: w_state_next = S_LDA;
                    OP_LDB_IMM: w_state_next = S_LDB;
                    OP_LDA_DIR, OP_LDB_DIR,
                    OP_STA_DIR, OP_STB_DIR: w_state_next = S_DIR_MAR;
                    default: w_state_next = S_F0;
                endcase
            end
            S_DIR_MAR: begin
                case (ctrl.IR)
                    OP_STA_DIR: w_state_next = S_STA;
                    OP_STB_DIR: w_state_next = S_STB;
                    OP_LDA_DIR, OP_LDB_DIR: w_state_next = S_DIR_WAIT;
                    default: w_state_next = S_F0;
                endcase
            end
            S_DIR_WAIT: begin
                case (ctrl.IR)
                    OP_LDA_DIR: w_state_next = S_LDA;
                    OP_LDB_DIR: w_state_next = S_LDB;
                    default:    w_state_next = S_F0;
                endcase
            end
            S_BR_WAIT: w_state_next = S_BR_LOAD;
            default:   w_state_next = S_F0;
        endcase
    end

    // Control word decode from the state register alone
    always_comb begin
        w_ir_load  = 1'b0;
        w_mar_load = 1'b0;
        w_pc_load  = 1'b0;
        w_pc_inc   = 1'b0;
        w_a_load   = 1'b0;
        w_b_load   = 1'b0;
        w_alu_sel  = ALU_ADD;
        w_ccr_load = 1'b0;
        w_from_sel = FROM_ALU;
        w_to_sel   = TO_PC;
        w_write    = 1'b0;
        case (r_state)
            S_F0, S_OPA: begin
                w_mar_load = 1'b1;
                w_from_sel = FROM_TOBUS;
                w_to_sel   = TO_PC;
            end
            S_F1, S_OPB: w_pc_inc = 1'b1;
            S_F2: begin
                w_ir_load  = 1'b1;
                w_from_sel = FROM_MEM;
            end
            S_LDA: begin
                w_a_load   = 1'b1;
                w_from_sel = FROM_MEM;
            end
            S_LDB: begin
                w_b_load   = 1'b1;
                w_from_sel = FROM_MEM;
            end
            S_DIR_MAR: begin
                w_mar_load = 1'b1;
                w_from_sel = FROM_MEM;
            end
            S_STA: begin
                w_write  = 1'b1;
                w_to_sel = TO_A;
            end
            S_STB: begin
                w_write  = 1'b1;
                w_to_sel = TO_B;
            end
            S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA: begin
                w_a_load   = 1'b1;
                w_ccr_load = 1'b1;
                w_from_sel = FROM_ALU;
                case (r_state)
                    S_SUB:   w_alu_sel = ALU_SUB;
                    S_AND:   w_alu_sel = ALU_AND;
                    S_OR:    w_alu_sel = ALU_OR;
                    S_INCA:  w_alu_sel = ALU_INCA;
                    S_DECA:  w_alu_sel = ALU_DECA;
                    default: w_alu_sel = ALU_ADD;
                endcase
            end
            S_BR_LOAD: begin
                w_pc_load  = 1'b1;
                w_from_sel = FROM_MEM;
            end
            default: ;  // S_D3, S_DIR_WAIT, S_BR_WAIT and illegal codes: no strobes
        endcase
    end

    assign ctrl.IR_LOAD             = w_ir_load;
    assign ctrl.MAR_LOAD            = w_mar_load;
    assign ctrl.PC_LOAD             = w_pc_load;
    assign ctrl.PC_INC              = w_pc_inc;
    assign ctrl.A_LOAD              = w_a_load;
    assign ctrl.B_LOAD              = w_b_load;
    assign ctrl.ALU_SEL             = w_alu_sel;
    assign ctrl.CCR_LOAD            = w_ccr_load;
    assign ctrl.FROM_MEMORY_BUS_SEL = w_from_sel;
    assign ctrl.TO_MEMORY_BUS_SEL   = w_to_sel;
    assign ctrl.write               = w_write;

endmodule
